// File: rtl/fa4_pkg.sv
// fa4_pkg: shared widths and types for the registered nibble adder.
package fa4_pkg;

  localparam int FA4_W = 4;

  // Addend / sum nibble
  typedef logic [FA4_W-1:0] nibble_t;

  // Carry-out in the MSB, sum nibble below it
  typedef logic [FA4_W:0] sum5_t;

endpackage

// File: rtl/fa4_fa1.sv
// fa1: combinational 1-bit full adder, one stage of the ripple chain.
module fa1 (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum and majority carry
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/fa4.sv
// fa4: registered 4-bit adder, {co, s} = a + b + ci with one cycle latency.
// Build option: define FA4_MBIT_EN to form the sum with one vector addition
// instead of the default ripple chain of fa1 instances.
module fa4
  import fa4_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [FA4_W-1:0] a,
  input  logic [FA4_W-1:0] b,
  input  logic             ci,
  output logic [FA4_W-1:0] s,
  output logic             co
);

  sum5_t sum_nxt_c;

`ifdef FA4_MBIT_EN

  // Single 5-bit addition; zero-extension keeps the carry in the MSB
  assign sum_nxt_c = sum5_t'(a) + sum5_t'(b) + sum5_t'(ci);

`else

  logic [FA4_W:0] carry_c;

  assign carry_c[0] = ci;

  // Ripple chain, carry flows from bit 0 upward
  for (genvar i = 0; i < FA4_W; i++) begin : g_rip
    fa1 u_fa1 (
      .a  (a[i]),
      .b  (b[i]),
      .ci (carry_c[i]),
      .s  (sum_nxt_c[i]),
      .co (carry_c[i+1])
    );
  end

  assign sum_nxt_c[FA4_W] = carry_c[FA4_W];

`endif

  // Output register, cleared asynchronously while rst is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s  <= '0;
      co <= 1'b0;
    end else begin
      s  <= sum_nxt_c[FA4_W-1:0];
      co <= sum_nxt_c[FA4_W];
    end
  end

endmodule

// File: tb/tb_fa4.sv
// tb_fa4: scoreboard bench for the registered nibble adder (either build).
module tb_fa4;
  import fa4_pkg::*;

  logic    clk;
  logic    rst;
  nibble_t a;
  nibble_t b;
  logic    ci;
  nibble_t s;
  logic    co;

  int n_cmp;
  int n_bad;

  sum5_t exp_q[$];
  sum5_t last_exp;

  fa4 dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .ci  (ci),
    .s   (s),
    .co  (co)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report a mismatch
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one operand set, confirm outputs hold until the edge, then score
  task automatic step(input string tag, input int av, input int bv, input int civ,
                      input bit chk_hold);
    sum5_t e;
    a  = nibble_t'(av);
    b  = nibble_t'(bv);
    ci = 1'(civ);
    exp_q.push_back(sum5_t'(av) + sum5_t'(bv) + sum5_t'(civ));
    #1;
    if (chk_hold) begin
      check({tag, "_hold_s"},  8'(s),  8'(last_exp[FA4_W-1:0]));
      check({tag, "_hold_co"}, 8'(co), 8'(last_exp[FA4_W]));
    end
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_s"},  8'(s),  8'(e[FA4_W-1:0]));
      check({tag, "_co"}, 8'(co), 8'(e[FA4_W]));
      last_exp = e;
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    last_exp = '0;
    rst = 1'b0;
    a   = 4'd9;
    b   = 4'd9;
    ci  = 1'b1;

    // Asynchronous reset before any clock edge
    #1 rst = 1'b1;
    #1;
    check("rst_s",  8'(s),  8'h0);
    check("rst_co", 8'(co), 8'h0);
    #1 rst = 1'b0;

    // First edge after reset loads 9+9+1
    step("post_rst", 9, 9, 1, 1'b0);
    check("post_rst_const_s",  8'(s),  8'h3);
    check("post_rst_const_co", 8'(co), 8'h1);

    // No carry
    step("nocarry", 7, 8, 0, 1'b1);
    step("zero",    0, 0, 0, 1'b1);

    // Wrap-around
    step("wrap_15_1",   15, 1, 0, 1'b1);
    step("wrap_5_10_1", 5, 10, 1, 1'b1);
    step("max",         15, 15, 1, 1'b1);
    check("max_const_s",  8'(s),  8'hf);
    check("max_const_co", 8'(co), 8'h1);

    // Latency: inputs change every cycle
    step("lat_a", 3, 4, 0, 1'b1);
    check("lat_a_const_s", 8'(s), 8'h7);
    step("lat_b", 9, 9, 1, 1'b1);
    check("lat_b_const_s",  8'(s),  8'h3);
    check("lat_b_const_co", 8'(co), 8'h1);

    // Mid-operation reset between edges
    #1 rst = 1'b1;
    #1;
    check("mid_rst_s",  8'(s),  8'h0);
    check("mid_rst_co", 8'(co), 8'h0);
    @(negedge clk);
    rst = 1'b0;
    last_exp = '0;

    // Exhaustive over {ci, a, b}
    for (int i = 0; i < 512; i++) begin
      step("exh", (i >> 4) & 15, i & 15, (i >> 8) & 1, 1'b1);
    end

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL leftover: %0d entries expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
